// File: rtl/matriz_barrido.sv
// matriz_barrido: row-scanning driver for an 8-row LED matrix.
// A frame snapshot of the row inputs is latched once per frame into a shadow
// buffer. Each row is then shown for PRESCALER cycles, and each row is
// preceded by BLANK_CYCLES of dark time. All outputs depend only on
// registered state.
module matriz_barrido #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int PRESCALER     = 1000,
    parameter int BLANK_CYCLES  = 2
) (
    input  logic                     BARRIDO_CLOCK,
    input  logic                     BARRIDO_RESET,
    input  logic                     BARRIDO_ENABLE_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_7_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_6_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_5_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_4_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_3_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_2_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_1_IN,
    input  logic [DATAWIDTH_BUS-1:0] BARRIDO_0_IN,
    output logic [DATAWIDTH_BUS-1:0] BARRIDO_FILA_OUT,
    output logic [DATAWIDTH_BUS-1:0] BARRIDO_COLUMNA_OUT,
    output logic                     BARRIDO_FRAME_OUT
);

    // The port list fixes eight physical rows; the index is 3 bits wide.
    localparam int ROWS = 8;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALER - 1);
    localparam logic [7:0]  BLANK_LAST = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;
    localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BLANK = 2'd2,
        SHOW  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               index_q, index_d;
    logic [15:0]              presc_cnt_q, presc_cnt_d;
    logic [7:0]               blank_cnt_q, blank_cnt_d;
    logic                     load_en;

    logic [DATAWIDTH_BUS-1:0] row_in   [ROWS];
    logic [DATAWIDTH_BUS-1:0] shadow_q [ROWS];
    logic [DATAWIDTH_BUS-1:0] shadow_d [ROWS];

    assign row_in[0] = BARRIDO_0_IN;
    assign row_in[1] = BARRIDO_1_IN;
    assign row_in[2] = BARRIDO_2_IN;
    assign row_in[3] = BARRIDO_3_IN;
    assign row_in[4] = BARRIDO_4_IN;
    assign row_in[5] = BARRIDO_5_IN;
    assign row_in[6] = BARRIDO_6_IN;
    assign row_in[7] = BARRIDO_7_IN;

    // Control state register: FSM state, row index and the two counters.
    always_ff @(posedge BARRIDO_CLOCK or negedge BARRIDO_RESET) begin
        if (!BARRIDO_RESET) begin
            state_q     <= IDLE;
            index_q     <= 3'd0;
            presc_cnt_q <= 16'd0;
            blank_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            presc_cnt_q <= presc_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // Next-state logic: ENABLE low overrides everything, including terminal counts.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        presc_cnt_d = presc_cnt_q;
        blank_cnt_d = blank_cnt_q;
        load_en     = 1'b0;

        if (!BARRIDO_ENABLE_IN) begin
            state_d     = IDLE;
            index_d     = 3'd0;
            presc_cnt_d = 16'd0;
            blank_cnt_d = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = LOAD;
                    presc_cnt_d = 16'd0;
                    blank_cnt_d = 8'd0;
                end
                LOAD: begin
                    load_en     = 1'b1;
                    index_d     = 3'd0;
                    presc_cnt_d = 16'd0;
                    blank_cnt_d = 8'd0;
                    state_d     = HAS_BLANK ? BLANK : SHOW;
                end
                BLANK: begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_d     = SHOW;
                        blank_cnt_d = 8'd0;
                        presc_cnt_d = 16'd0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 8'd1;
                    end
                end
                SHOW: begin
                    if (presc_cnt_q == PRESC_LAST) begin
                        presc_cnt_d = 16'd0;
                        blank_cnt_d = 8'd0;
                        if (index_q == 3'd7) begin
                            index_d = 3'd0;
                            state_d = LOAD;
                        end else begin
                            index_d = index_q + 3'd1;
                            state_d = HAS_BLANK ? BLANK : SHOW;
                        end
                    end else begin
                        presc_cnt_d = presc_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Shadow buffer: one register per row, written only during LOAD so frames never tear.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_shadow
            always_comb begin
                shadow_d[gi] = load_en ? row_in[gi] : shadow_q[gi];
            end

            // Row gi snapshot register.
            always_ff @(posedge BARRIDO_CLOCK or negedge BARRIDO_RESET) begin
                if (!BARRIDO_RESET) begin
                    shadow_q[gi] <= '0;
                end else begin
                    shadow_q[gi] <= shadow_d[gi];
                end
            end
        end
    endgenerate

    // Moore output decode: driven from registered state only.
    always_comb begin
        BARRIDO_FILA_OUT    = '0;
        BARRIDO_COLUMNA_OUT = '0;
        BARRIDO_FRAME_OUT   = 1'b0;
        case (state_q)
            LOAD: begin
                BARRIDO_FRAME_OUT = 1'b1;
            end
            SHOW: begin
                BARRIDO_FILA_OUT    = {{(DATAWIDTH_BUS-1){1'b0}}, 1'b1} << index_q;
                BARRIDO_COLUMNA_OUT = shadow_q[index_q];
            end
            default: begin
                BARRIDO_FILA_OUT    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_matriz_barrido.sv
// Bench for matriz_barrido: expected output streams are generated from the
// frame structure and checked cycle by cycle from a scoreboard queue.
module tb_matriz_barrido;

    localparam int P         = 4;
    localparam int B         = 1;
    localparam int ROW_CYC   = P + B;
    localparam int FRAME_CYC = 1 + 8 * ROW_CYC;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       en_f  = 1'b0;
    logic [7:0] rin [8];
    logic [7:0] fila, col, fila_f, col_f;
    logic       frame, frame_f;

    always #5 clk = ~clk;

    matriz_barrido #(.DATAWIDTH_BUS(8), .PRESCALER(P), .BLANK_CYCLES(B)) dut (
        .BARRIDO_CLOCK      (clk),
        .BARRIDO_RESET      (rst_n),
        .BARRIDO_ENABLE_IN  (en),
        .BARRIDO_7_IN       (rin[7]),
        .BARRIDO_6_IN       (rin[6]),
        .BARRIDO_5_IN       (rin[5]),
        .BARRIDO_4_IN       (rin[4]),
        .BARRIDO_3_IN       (rin[3]),
        .BARRIDO_2_IN       (rin[2]),
        .BARRIDO_1_IN       (rin[1]),
        .BARRIDO_0_IN       (rin[0]),
        .BARRIDO_FILA_OUT   (fila),
        .BARRIDO_COLUMNA_OUT(col),
        .BARRIDO_FRAME_OUT  (frame)
    );

    matriz_barrido #(.DATAWIDTH_BUS(8), .PRESCALER(1), .BLANK_CYCLES(0)) dut_fast (
        .BARRIDO_CLOCK      (clk),
        .BARRIDO_RESET      (rst_n),
        .BARRIDO_ENABLE_IN  (en_f),
        .BARRIDO_7_IN       (rin[7]),
        .BARRIDO_6_IN       (rin[6]),
        .BARRIDO_5_IN       (rin[5]),
        .BARRIDO_4_IN       (rin[4]),
        .BARRIDO_3_IN       (rin[3]),
        .BARRIDO_2_IN       (rin[2]),
        .BARRIDO_1_IN       (rin[1]),
        .BARRIDO_0_IN       (rin[0]),
        .BARRIDO_FILA_OUT   (fila_f),
        .BARRIDO_COLUMNA_OUT(col_f),
        .BARRIDO_FRAME_OUT  (frame_f)
    );

    typedef struct packed {
        logic [7:0] fila;
        logic [7:0] col;
        logic       frame;
    } exp_t;

    // Row data in (row n at bits 8n+7:8n) and the column value expected while row n is shown.
    typedef struct packed {
        logic [63:0] rows;
        logic [63:0] exp_cols;
    } vec_t;

    exp_t sb_q[$];
    exp_t sbf_q[$];
    vec_t vecs [4];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [63:0] BASE = 64'h8040_2010_0804_0201;

    task automatic set_rows(input logic [63:0] v);
        for (int r = 0; r < 8; r++) rin[r] = v[8*r +: 8];
    endtask

    task automatic exp_idle(input int n, input bit fast);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) begin
            if (fast) sbf_q.push_back(e);
            else      sb_q.push_back(e);
        end
    endtask

    // One full frame: LOAD pulse, then per row B dark cycles and P lit cycles.
    task automatic exp_frame(input logic [63:0] cols);
        exp_t e;
        e = '0;
        e.frame = 1'b1;
        sb_q.push_back(e);
        for (int r = 0; r < 8; r++) begin
            e = '0;
            for (int k = 0; k < B; k++) sb_q.push_back(e);
            e.fila = 8'b1 << r;
            e.col  = cols[8*r +: 8];
            for (int k = 0; k < P; k++) sb_q.push_back(e);
        end
    endtask

    // Fast instance: no blanking, one cycle per row.
    task automatic exp_frame_fast(input logic [63:0] cols);
        exp_t e;
        e = '0;
        e.frame = 1'b1;
        sbf_q.push_back(e);
        for (int r = 0; r < 8; r++) begin
            e.frame = 1'b0;
            e.fila  = 8'b1 << r;
            e.col   = cols[8*r +: 8];
            sbf_q.push_back(e);
        end
    endtask

    task automatic check_n(input int n, input string name, input bit fast);
        exp_t e;
        exp_t got;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_checks++;
            got = fast ? {fila_f, col_f, frame_f} : {fila, col, frame};
            if ((fast ? sbf_q.size() : sb_q.size()) == 0) begin
                n_fail++;
                $display("FAIL %s cyc %0d: scoreboard empty, got fila=%h col=%h frame=%b",
                         name, i, got.fila, got.col, got.frame);
            end else begin
                e = fast ? sbf_q.pop_front() : sb_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s cyc %0d: got fila=%h col=%h frame=%b, expected fila=%h col=%h frame=%b",
                             name, i, got.fila, got.col, got.frame, e.fila, e.col, e.frame);
                end
            end
        end
    endtask

    task automatic check_zero_now(input string name);
        n_checks++;
        if ({fila, col, frame, fila_f, col_f, frame_f} !== '0) begin
            n_fail++;
            $display("FAIL %s: got fila=%h col=%h frame=%b fast fila=%h col=%h frame=%b, expected all zero",
                     name, fila, col, frame, fila_f, col_f, frame_f);
        end
    endtask

    initial begin
        vecs[0] = '{rows: BASE,                  exp_cols: 64'h8040_2010_0804_0201};
        vecs[1] = '{rows: 64'hFF00_AA55_0F0F_C3A5, exp_cols: 64'hFF00_AA55_0F0F_C3A5};
        vecs[2] = '{rows: 64'h0000_0000_0000_0000, exp_cols: 64'h0000_0000_0000_0000};
        vecs[3] = '{rows: 64'h1234_5678_9ABC_DEF0, exp_cols: 64'h1234_5678_9ABC_DEF0};
        set_rows(64'h0);

        // Asynchronous reset with no clock edge in between.
        #1 rst_n = 1'b0;
        #1 check_zero_now("reset_async");

        // Enable is ignored while reset is held.
        en = 1'b1;
        en_f = 1'b1;
        exp_idle(2, 1'b0);
        check_n(2, "reset_hold", 1'b0);
        en = 1'b0;
        en_f = 1'b0;
        rst_n = 1'b1;
        exp_idle(2, 1'b0);
        check_n(2, "idle_after_reset", 1'b0);

        // Table vectors: two back-to-back frames each, enable drop on the terminal count.
        for (int v = 0; v < 4; v++) begin
            set_rows(vecs[v].rows);
            en = 1'b1;
            exp_frame(vecs[v].exp_cols);
            exp_frame(vecs[v].exp_cols);
            check_n(2 * FRAME_CYC, $sformatf("vec%0d", v), 1'b0);
            en = 1'b0;
            exp_idle(2, 1'b0);
            check_n(2, $sformatf("vec%0d_stop", v), 1'b0);
        end

        // Row 3 changes during row 1 SHOW: visible only after the next LOAD.
        set_rows(BASE);
        en = 1'b1;
        exp_frame(BASE);
        exp_frame({BASE[63:32], 8'hFF, BASE[23:0]});
        check_n(1 + ROW_CYC + B + 1, "tear_pre", 1'b0);
        rin[3] = 8'hFF;
        check_n(2 * FRAME_CYC - (1 + ROW_CYC + B + 1), "tear_post", 1'b0);
        en = 1'b0;
        exp_idle(1, 1'b0);
        check_n(1, "tear_stop", 1'b0);
        rin[3] = 8'h08;

        // Enable dropped mid row 5 SHOW, then restarted from LOAD/row 0.
        en = 1'b1;
        exp_frame(BASE);
        check_n(1 + 5 * ROW_CYC + B + 2, "drop_pre", 1'b0);
        en = 1'b0;
        sb_q.delete();
        exp_idle(3, 1'b0);
        check_n(3, "drop_idle", 1'b0);
        en = 1'b1;
        exp_frame(BASE);
        check_n(FRAME_CYC, "reenable", 1'b0);
        en = 1'b0;
        exp_idle(1, 1'b0);
        check_n(1, "reenable_stop", 1'b0);

        // Reset pulled low mid row 6 SHOW, away from any clock edge.
        en = 1'b1;
        exp_frame(BASE);
        check_n(1 + 6 * ROW_CYC + B + 2, "rst_pre", 1'b0);
        #2 rst_n = 1'b0;
        #1 check_zero_now("rst_mid_row6");
        sb_q.delete();
        exp_idle(2, 1'b0);
        check_n(2, "rst_mid_hold", 1'b0);
        rst_n = 1'b1;
        set_rows(vecs[1].rows);
        exp_frame(vecs[1].exp_cols);
        check_n(FRAME_CYC, "rst_restart", 1'b0);
        en = 1'b0;
        exp_idle(1, 1'b0);
        check_n(1, "rst_restart_stop", 1'b0);

        // No blanking, one cycle per row: period 9.
        set_rows(BASE);
        en_f = 1'b1;
        for (int f = 0; f < 3; f++) exp_frame_fast(BASE);
        check_n(27, "fast_scan", 1'b1);
        en_f = 1'b0;
        exp_idle(1, 1'b1);
        check_n(1, "fast_stop", 1'b1);

        // Random data and enable toggling: row select stays zero or one-hot.
        for (int c = 0; c < 10 * FRAME_CYC; c++) begin
            @(negedge clk);
            n_checks++;
            if (!$onehot0(fila) || (col != 8'h00 && fila == 8'h00)) begin
                n_fail++;
                $display("FAIL random_invariant cyc %0d: got fila=%h col=%h, expected fila zero/one-hot and col zero when fila zero",
                         c, fila, col);
            end
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) rin[$urandom_range(0, 7)] = 8'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
